// File: rtl/rans_decode_stream.sv
// rans_decode_stream: streaming rANS decoder.
// Loads the flushed encoder state from a pre-reversed byte stream, then
// decodes one symbol per step (slot lookup, frequency lookup, state update,
// byte renormalisation) and emits symbols over a valid/ready handshake.
// Optional feature macro: RANS_DEC_CHECK_EN adds the final-state check on err_o.
module rans_decode_stream #(
   parameter int RESOLUTION   = 10,
   parameter int SYMBOL_WIDTH = 8,
   parameter int COUNT_WIDTH  = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    freq_wr_i,
   input  logic [SYMBOL_WIDTH-1:0] freq_addr_i,
   input  logic [RESOLUTION-1:0]   freq_i,
   input  logic [RESOLUTION-1:0]   cum_freq_i,
   input  logic                    slot_wr_i,
   input  logic [RESOLUTION-1:0]   slot_addr_i,
   input  logic [SYMBOL_WIDTH-1:0] slot_symb_i,
   input  logic                    start_i,
   input  logic [COUNT_WIDTH-1:0]  num_symbols_i,
   input  logic                    byte_valid_i,
   input  logic [SYMBOL_WIDTH-1:0] byte_i,
   output logic                    byte_ready_o,
   output logic                    symb_valid_o,
   output logic [SYMBOL_WIDTH-1:0] symb_o,
   input  logic                    symb_ready_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    err_o
);

   localparam int STATE_WIDTH = RESOLUTION + SYMBOL_WIDTH;
   localparam int LOAD_BYTES  = (STATE_WIDTH + SYMBOL_WIDTH - 1) / SYMBOL_WIDTH;
   localparam logic [1:0] LOAD_LAST = 2'(LOAD_BYTES - 1);
   localparam logic [STATE_WIDTH-1:0] L_MIN =
      {{(SYMBOL_WIDTH-1){1'b0}}, 1'b1, {RESOLUTION{1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_LOOKUP, S_FREQ, S_COMPUTE, S_RENORM, S_EMIT, S_DONE
   } state_t;

   state_t                   r_fsm;
   state_t                   w_next;
   logic [STATE_WIDTH-1:0]   r_state;
   logic [COUNT_WIDTH-1:0]   r_count;
   logic [1:0]               r_byte_cnt;
   logic [SYMBOL_WIDTH-1:0]  r_s;
   logic [RESOLUTION-1:0]    r_f;
   logic [RESOLUTION-1:0]    r_c;
   logic                     r_byte_ready;
   logic                     r_symb_valid;
   logic                     r_busy;
   logic                     r_done;

   logic [SYMBOL_WIDTH-1:0]  r_slot_mem [0:(1<<RESOLUTION)-1];
   logic [2*RESOLUTION-1:0]  r_freq_mem [0:(1<<SYMBOL_WIDTH)-1];

   logic [STATE_WIDTH-1:0]   w_shift;
   logic [STATE_WIDTH-1:0]   w_comp;
   logic                     w_take;
   logic                     w_symb_hs;

   // Byte shifted into the low end of the state (LOAD truncates, RENORM never overflows).
   assign w_shift   = {r_state[STATE_WIDTH-SYMBOL_WIDTH-1:0], byte_i};
   // Decoder state update: f * (x / M) + (x mod M) - c.
   assign w_comp    = ({{SYMBOL_WIDTH{1'b0}}, r_f} * (r_state >> RESOLUTION))
                    + {{SYMBOL_WIDTH{1'b0}}, r_state[RESOLUTION-1:0]}
                    - {{SYMBOL_WIDTH{1'b0}}, r_c};
   assign w_take    = byte_valid_i & r_byte_ready;
   assign w_symb_hs = r_symb_valid & symb_ready_i;

   // Table writes: plain RAM, no reset, writable at any time.
   always_ff @(posedge clk_i) begin
      if (slot_wr_i) begin
         r_slot_mem[slot_addr_i] <= slot_symb_i;
      end
      if (freq_wr_i) begin
         r_freq_mem[freq_addr_i] <= {freq_i, cum_freq_i};
      end
   end

   // FSM state register.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_fsm <= S_IDLE;
      end else begin
         r_fsm <= w_next;
      end
   end

   // Next-state logic; COMPUTE skips RENORM when no byte is needed.
   always_comb begin
      w_next = r_fsm;
      case (r_fsm)
         S_IDLE: begin
            if (start_i) begin
               w_next = (num_symbols_i == {COUNT_WIDTH{1'b0}}) ? S_DONE : S_LOAD;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_LOAD: begin
            if (w_take && (r_byte_cnt == LOAD_LAST)) begin
               w_next = S_LOOKUP;
            end else begin
               w_next = S_LOAD;
            end
         end
         S_LOOKUP:  w_next = S_FREQ;
         S_FREQ:    w_next = S_COMPUTE;
         S_COMPUTE: w_next = (w_comp < L_MIN) ? S_RENORM : S_EMIT;
         S_RENORM: begin
            if (w_take && (w_shift >= L_MIN)) begin
               w_next = S_EMIT;
            end else begin
               w_next = S_RENORM;
            end
         end
         S_EMIT: begin
            if (w_symb_hs) begin
               w_next = (r_count == COUNT_WIDTH'(1)) ? S_DONE : S_LOOKUP;
            end else begin
               w_next = S_EMIT;
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath: state, symbol counter, load byte counter and table read registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state    <= {STATE_WIDTH{1'b0}};
         r_count    <= {COUNT_WIDTH{1'b0}};
         r_byte_cnt <= 2'd0;
         r_s        <= {SYMBOL_WIDTH{1'b0}};
         r_f        <= {RESOLUTION{1'b0}};
         r_c        <= {RESOLUTION{1'b0}};
      end else begin
         case (r_fsm)
            S_IDLE: begin
               if (start_i) begin
                  r_count    <= num_symbols_i;
                  r_state    <= {STATE_WIDTH{1'b0}};
                  r_byte_cnt <= 2'd0;
               end
            end
            S_LOAD: begin
               if (w_take) begin
                  r_state    <= w_shift;
                  r_byte_cnt <= r_byte_cnt + 2'd1;
               end
            end
            S_LOOKUP:  r_s <= r_slot_mem[r_state[RESOLUTION-1:0]];
            S_FREQ:    {r_f, r_c} <= r_freq_mem[r_s];
            S_COMPUTE: r_state <= w_comp;
            S_RENORM: begin
               if (w_take) begin
                  r_state <= w_shift;
               end
            end
            S_EMIT: begin
               if (w_symb_hs) begin
                  r_count <= r_count - COUNT_WIDTH'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Registered handshake/status outputs decoded from the next state.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_byte_ready <= 1'b0;
         r_symb_valid <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_byte_ready <= (w_next == S_LOAD) || (w_next == S_RENORM);
         r_symb_valid <= (w_next == S_EMIT);
         r_busy       <= (w_next != S_IDLE);
         r_done       <= (w_next == S_DONE);
      end
   end

   assign byte_ready_o = r_byte_ready;
   assign symb_valid_o = r_symb_valid;
   assign symb_o       = r_s;
   assign busy_o       = r_busy;
   assign done_o       = r_done;

`ifdef RANS_DEC_CHECK_EN
   logic r_err;

   // Final-state check: a clean stream ends exactly at L_MIN; visible with done_o.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_err <= 1'b0;
      end else if ((r_fsm == S_IDLE) && start_i) begin
         r_err <= 1'b0;
      end else if ((r_fsm == S_EMIT) && (w_next == S_DONE)) begin
         r_err <= (r_state != L_MIN);
      end
   end

   assign err_o = r_err;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: doc/rans_decode_stream.md
# rans_decode_stream

Streaming rANS decoder, the receive-side counterpart of the encoder stream. It consumes the encoded byte stream and reproduces the original symbols using the same frequency model as the encoder. The byte stream is supplied already reversed by the upstream LIFO buffer. The block loads the flushed state, then decodes one symbol per step with byte renormalisation, and emits symbols over a valid/ready handshake.

## Interface
- RESOLUTION, 10, log2 of the probability scale M; the renorm floor is L_MIN = 2^RESOLUTION.
- SYMBOL_WIDTH, 8, symbol and stream-byte width; STATE_WIDTH = RESOLUTION + SYMBOL_WIDTH; L_MAX = L_MIN << SYMBOL_WIDTH.
- COUNT_WIDTH, 16, width of the symbol count.
- clk_i  in  1  sole clock.
- rst_ni  in  1  reset, synchronous, active-low.
- freq_wr_i  in  1  write {freq_i, cum_freq_i} into the frequency table at freq_addr_i.
- freq_addr_i  in  SYMBOL_WIDTH  frequency-table address (symbol).
- freq_i  in  RESOLUTION  symbol frequency.
- cum_freq_i  in  RESOLUTION  cumulative frequency.
- slot_wr_i  in  1  write slot_symb_i into the slot table at slot_addr_i.
- slot_addr_i  in  RESOLUTION  slot index, 0..M-1.
- slot_symb_i  in  SYMBOL_WIDTH  symbol owning that slot.
- start_i  in  1  begin a frame; sampled only in IDLE.
- num_symbols_i  in  COUNT_WIDTH  symbols in the frame; latched on start.
- byte_valid_i  in  1  stream byte valid.
- byte_i  in  SYMBOL_WIDTH  stream byte.
- byte_ready_o  out  1  block accepts byte_i this cycle.
- symb_valid_o  out  1  decoded symbol valid.
- symb_o  out  SYMBOL_WIDTH  decoded symbol.
- symb_ready_i  in  1  downstream accepts the symbol.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse at frame end.
- err_o  out  1  final-state mismatch flag; only present with the check feature (see Configuration).

## Operation
- Tables are block RAM with no reset, written at any time; contents are not protected while busy.
- FSM states: IDLE, LOAD, LOOKUP, FREQ, COMPUTE, RENORM, EMIT, DONE.
- IDLE: on start_i, latch num_symbols_i into a remaining-symbol counter and clear state and byte count.
  - Count 0: go to DONE.
  - Otherwise: go to LOAD.
- LOAD: byte_ready_o=1. Accept ceil(STATE_WIDTH/SYMBOL_WIDTH)=3 bytes, MSB first: state <= (state<<SYMBOL_WIDTH)|byte_i, truncated to STATE_WIDTH. After the 3rd byte, go to LOOKUP.
- LOOKUP: read the slot table at state[RESOLUTION-1:0], registered (s_r).
- FREQ: read the frequency table at s_r, registered (f_r, c_r).
- COMPUTE: state <= f_r*(state>>RESOLUTION) + state[RESOLUTION-1:0] - c_r, computed in STATE_WIDTH bits; the result never overflows for a valid stream. Go to RENORM.
- RENORM: if state < L_MIN, byte_ready_o=1 and each accepted byte does state <= (state<<SYMBOL_WIDTH)|byte_i. Leave when state >= L_MIN. At most 2 bytes are needed; the state is not truncated.
- EMIT: symb_valid_o=1, symb_o=s_r, held stable until symb_ready_i. On handshake, decrement the counter; go to DONE if it is now 0, else LOOKUP.
- DONE: done_o=1 for one cycle, then IDLE.
- byte_ready_o is 0 outside LOAD and RENORM-with-deficit; bytes presented then are not consumed.
- start_i while busy is ignored.

## Timing
- Reset (rst_ni=0 at a clk_i edge): FSM to IDLE; state, counter, s_r cleared; byte_ready_o, symb_valid_o, busy_o, done_o, err_o = 0. Reset mid-frame abandons the frame with no done_o.
- With byte_valid_i held high: start to first EMIT = 1 (IDLE) + 3 (LOAD) + 3 (LOOKUP/FREQ/COMPUTE) + k (RENORM bytes, 0-2) cycles.
- Per-symbol throughput: 4 + k cycles when symb_ready_i is high, i.e. the EMIT cycle plus 3 pipeline cycles plus k renorm bytes.
- RENORM with k=0 occupies 0 cycles: COMPUTE goes directly to EMIT.
- Byte starvation stalls LOAD or RENORM indefinitely with no state change.
- symb_valid_o must not drop before the handshake.

## Configuration
- RANS_DEC_CHECK_EN defined: err_o is registered. In the DONE cycle it is set to (state != L_MIN) for frames with num_symbols > 0. It holds until the next start_i or reset.
- Not defined: err_o is tied to 0 and no comparator is built.

## Test plan
All scenarios use tables T1 (sym0 freq 512 cum 0 on slots 0-511; sym1 freq 512 cum 512 on slots 512-1023) unless T2 is named.
- T1, N=1, bytes 00 04 00 12: state 1024, then sym0, then 512, then RENORM consumes 0x12 giving 131090. Check: symb_o=0, done_o pulse, err_o=1 (check enabled).
- T1, N=1, bytes 00 08 00: sym0, state 1024, no renorm byte consumed. Check: done_o, err_o=0.
- T1, N=1, bytes 03 FF FF: sym1, state 131071. Check: byte_ready_o stays 0 after LOAD.
- T2 (sym5 freq 1 cum 1023 on slot 1023; rest sym0 freq 1023 cum 0), N=1, bytes 00 07 FF AA BB: sym5, state 1 → 0x1AA → 0x1AABB. Check: exactly 2 RENORM bytes consumed.
- symb_ready_i low for 5 cycles during EMIT: symb_valid_o/symb_o held, no byte consumed. N=0 start: done_o 2 cycles later, no symbols.
- rst_ni low during RENORM: next cycle all outputs 0 and FSM in IDLE. A fresh start then decodes correctly.
